quad_color_ctrl: RTL and testbench

//   Owns the 4-entry x 24-bit quadrant colour table that feeds the VGA pixel mux.

---
 rtl/quad_color_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_quad_color_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/quad_color_ctrl.sv
// Quadrant colour table: debounced panel writes and a demo rotator update a shadow table,
// which is copied to the live colour outputs only on frame_start.
module quad_color_ctrl #(
   parameter int DEB_CYCLES  = 1000000,
   parameter int DEMO_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_n,
   input  logic [1:0]  sw_quad,
   input  logic [1:0]  sw_chan,
   input  logic [7:0]  sw_val,
   input  logic        demo_en,
   input  logic        frame_start,
   output logic [23:0] color0,
   output logic [23:0] color1,
   output logic [23:0] color2,
   output logic [23:0] color3,
   output logic        busy,
   output logic [7:0]  wr_count
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int FW = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;

   typedef enum logic {S_IDLE, S_ROTATE} state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic            deb_q, deb_d;
   logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
   logic            press_q, press_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic            pend_q, pend_d;
   logic            hold_q, hold_d;
   logic [1:0]      hold_quad_q, hold_quad_d;
   logic [1:0]      hold_chan_q, hold_chan_d;
   logic [7:0]      hold_val_q, hold_val_d;
   logic [23:0]     shadow_q [4];
   logic [23:0]     shadow_d [4];
   logic [23:0]     color_q [4];
   logic [23:0]     color_d [4];
   logic            dirty_q, dirty_d;
   logic [7:0]      wr_cnt_q, wr_cnt_d;
   logic            do_wr;
   logic [1:0]      wr_quad, wr_chan;
   logic [7:0]      wr_val;

   // Debounce: the counter only runs while the synced level disagrees with the debounced one.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      press_d   = 1'b0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
            deb_d   = sync2_q;
            press_d = deb_q & ~sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      pend_d      = pend_q;
      hold_d      = hold_q;
      hold_quad_d = hold_quad_q;
      hold_chan_d = hold_chan_q;
      hold_val_d  = hold_val_q;
      shadow_d    = shadow_q;
      color_d     = color_q;
      dirty_d     = dirty_q;
      wr_cnt_d    = wr_cnt_q;
      do_wr       = 1'b0;
      wr_quad     = sw_quad;
      wr_chan     = sw_chan;
      wr_val      = sw_val;

      // Commit reads the pre-write shadow; a same-cycle write re-sets dirty below.
      if (frame_start && dirty_q) begin
         color_d = shadow_q;
         dirty_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (hold_q) begin
               do_wr   = 1'b1;
               wr_quad = hold_quad_q;
               wr_chan = hold_chan_q;
               wr_val  = hold_val_q;
               hold_d  = 1'b0;
            end else if (press_q) begin
               do_wr = 1'b1;
            end else if (pend_q) begin
               state_d = S_ROTATE;
            end
         end
         S_ROTATE: begin
            for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[(i + 3) % 4];
            dirty_d  = 1'b1;
            wr_cnt_d = wr_cnt_q + 8'd1;
            pend_d   = 1'b0;
            state_d  = S_IDLE;
            if (press_q) begin
               hold_d      = 1'b1;
               hold_quad_d = sw_quad;
               hold_chan_d = sw_chan;
               hold_val_d  = sw_val;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_wr && wr_chan != 2'b11) begin
         shadow_d[wr_quad][{wr_chan, 3'b000} +: 8] = wr_val;
         dirty_d  = 1'b1;
         wr_cnt_d = wr_cnt_q + 8'd1;
      end

      if (!demo_en) begin
         fcnt_d = '0;
         pend_d = 1'b0;
      end else if (frame_start) begin
         if (fcnt_q == FW'(DEMO_FRAMES - 1)) begin
            fcnt_d = '0;
            pend_d = 1'b1;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_cnt_q   <= '0;
         press_q     <= 1'b0;
         fcnt_q      <= '0;
         pend_q      <= 1'b0;
         hold_q      <= 1'b0;
         hold_quad_q <= '0;
         hold_chan_q <= '0;
         hold_val_q  <= '0;
         dirty_q     <= 1'b0;
         wr_cnt_q    <= '0;
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
            color_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         sync1_q     <= key_n;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         press_q     <= press_d;
         fcnt_q      <= fcnt_d;
         pend_q      <= pend_d;
         hold_q      <= hold_d;
         hold_quad_q <= hold_quad_d;
         hold_chan_q <= hold_chan_d;
         hold_val_q  <= hold_val_d;
         dirty_q     <= dirty_d;
         wr_cnt_q    <= wr_cnt_d;
         shadow_q    <= shadow_d;
         color_q     <= color_d;
      end
   end

   assign color0   = color_q[0];
   assign color1   = color_q[1];
   assign color2   = color_q[2];
   assign color3   = color_q[3];
   assign busy     = dirty_q;
   assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_quad_color_ctrl.sv
// Directed bench for quad_color_ctrl with short debounce (4) and demo period (3 frames).
module tb_quad_color_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_n = 1'b1;
   logic [1:0]  sw_quad = '0;
   logic [1:0]  sw_chan = '0;
   logic [7:0]  sw_val = '0;
   logic        demo_en = 1'b0;
   logic        frame_start = 1'b0;
   logic [23:0] color0, color1, color2, color3;
   logic        busy;
   logic [7:0]  wr_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   quad_color_ctrl #(.DEB_CYCLES(4), .DEMO_FRAMES(3)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .sw_quad(sw_quad), .sw_chan(sw_chan),
      .sw_val(sw_val), .demo_en(demo_en), .frame_start(frame_start),
      .color0(color0), .color1(color1), .color2(color2), .color3(color3),
      .busy(busy), .wr_count(wr_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic check_colors(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3);
      check({tag, ".c0"}, {8'h0, color0}, {8'h0, e0});
      check({tag, ".c1"}, {8'h0, color1}, {8'h0, e1});
      check({tag, ".c2"}, {8'h0, color2}, {8'h0, e2});
      check({tag, ".c3"}, {8'h0, color3}, {8'h0, e3});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      frame_start = 1'b1;
      cycles(1);
      frame_start = 1'b0;
      cycles(1);
   endtask

   task automatic press(input logic [1:0] q, input logic [1:0] c, input logic [7:0] v,
                        input int low);
      sw_quad = q;
      sw_chan = c;
      sw_val  = v;
      key_n   = 1'b0;
      cycles(low);
      key_n = 1'b1;
      cycles(12);
   endtask

   initial begin
      cycles(3);
      check_colors("rst", 24'h0, 24'h0, 24'h0, 24'h0);
      check("rst.busy", {31'h0, busy}, 32'h0);
      check("rst.wr", {24'h0, wr_count}, 32'h0);
      rst = 1'b0;
      cycles(2);

      // 1: basic panel write then commit
      press(2'd2, 2'b10, 8'hA5, 10);
      check("t1.busy", {31'h0, busy}, 32'h1);
      check("t1.wr", {24'h0, wr_count}, 32'd1);
      check("t1.c2_pre", {8'h0, color2}, 32'h0);
      frame();
      check("t1.c2", {8'h0, color2}, 32'hA50000);
      check("t1.busy_post", {31'h0, busy}, 32'h0);

      // 2: glitch shorter than debounce, then reserved channel
      press(2'd0, 2'b00, 8'hFF, 2);
      check("t2.glitch_wr", {24'h0, wr_count}, 32'd1);
      press(2'd1, 2'b11, 8'h77, 10);
      check("t2.rsv_wr", {24'h0, wr_count}, 32'd1);
      check("t2.rsv_busy", {31'h0, busy}, 32'h0);

      // 3: load 01..04 on B, commit, then one demo rotation
      press(2'd0, 2'b00, 8'h01, 10);
      press(2'd1, 2'b00, 8'h02, 10);
      press(2'd2, 2'b00, 8'h03, 10);
      press(2'd2, 2'b10, 8'h00, 10);
      press(2'd3, 2'b00, 8'h04, 10);
      frame();
      check_colors("t3.load", 24'h01, 24'h02, 24'h03, 24'h04);
      check("t3.wr_load", {24'h0, wr_count}, 32'd6);
      demo_en = 1'b1;
      frame();
      frame();
      frame();
      cycles(2);
      demo_en = 1'b0;
      check("t3.wr_rot", {24'h0, wr_count}, 32'd7);
      check("t3.busy", {31'h0, busy}, 32'h1);
      check("t3.c0_pre", {8'h0, color0}, 32'h01);
      frame();
      check_colors("t3.rot", 24'h04, 24'h01, 24'h02, 24'h03);

      // 4: press and demo pending become active in the same cycle
      demo_en = 1'b1;
      frame();
      frame();
      sw_quad = 2'd1;
      sw_chan = 2'b01;
      sw_val  = 8'h55;
      key_n   = 1'b0;
      cycles(5);
      frame_start = 1'b1;
      cycles(1);
      frame_start = 1'b0;
      cycles(4);
      key_n = 1'b1;
      cycles(12);
      demo_en = 1'b0;
      check("t4.wr", {24'h0, wr_count}, 32'd9);
      check_colors("t4.pre", 24'h04, 24'h01, 24'h02, 24'h03);
      frame();
      check_colors("t4.post", 24'h03, 24'h04, 24'h005501, 24'h02);

      // 5: press lands on a frame_start cycle while shadow is already dirty
      press(2'd3, 2'b00, 8'h33, 10);
      sw_quad = 2'd0;
      sw_chan = 2'b10;
      sw_val  = 8'h11;
      key_n   = 1'b0;
      cycles(6);
      frame_start = 1'b1;
      cycles(1);
      frame_start = 1'b0;
      cycles(4);
      key_n = 1'b1;
      cycles(12);
      check_colors("t5.same", 24'h03, 24'h04, 24'h005501, 24'h33);
      check("t5.busy", {31'h0, busy}, 32'h1);
      check("t5.wr", {24'h0, wr_count}, 32'd11);
      frame();
      check("t5.c0", {8'h0, color0}, 32'h110003);
      check("t5.busy_post", {31'h0, busy}, 32'h0);

      // 6: async reset mid-debounce with demo pending
      demo_en = 1'b1;
      frame();
      frame();
      sw_quad = 2'd2;
      sw_chan = 2'b00;
      sw_val  = 8'hEE;
      key_n   = 1'b0;
      cycles(2);
      frame_start = 1'b1;
      cycles(1);
      frame_start = 1'b0;
      rst = 1'b1;
      #1;
      check_colors("t6.async", 24'h0, 24'h0, 24'h0, 24'h0);
      check("t6.busy", {31'h0, busy}, 32'h0);
      check("t6.wr", {24'h0, wr_count}, 32'h0);
      key_n = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(20);
      check("t6.wr_after", {24'h0, wr_count}, 32'h0);
      check("t6.busy_after", {31'h0, busy}, 32'h0);
      demo_en = 1'b0;
      frame();
      check_colors("t6.after", 24'h0, 24'h0, 24'h0, 24'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
